dcache_flush_engine: RTL and testbench
======================================

Name: dcache_flush_engine

Overview:
- Write-back initiator on the far side of the dcache memory array's dirty-probe interface.
- On a flush request, walks every {way, set} line, probes its dirty bit, and issues one memory STORE per dirty block.
- Clears each dirty bit after the memory bus accepts the store.
- Used before halt or a coherence drain; owns the proc2mem bus while busy.

Parameters:
- NUM_WAYS, 4, ways per set (power of two)
- NUM_SETS, 8, sets per way (power of two)
- TAG_W, 26, tag width; TAG_W + log2(NUM_SETS) + 3 = 32
- BLK_W, 64, block width in bits
- RESP_W, 4, memory response tag width; 0 = not accepted

Ports:
- clock  in  1  single clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- flush_req  in  1  start a flush; sampled only in IDLE
- flush_busy  out  1  high in every state except IDLE
- flush_done  out  1  one-cycle pulse when the walk completes
- dirty_search  out  1  selects the probe path in the cache array
- way_selected  out  3  way being probed; bit 2 tied 0
- rd_set_idx  out  3  set being probed
- read_dirty  in  1  dirty bit of the probed line, same cycle (combinational)
- dirty_tag  in  TAG_W  tag of the probed line
- dirty_idx  in  3  index of the probed line
- dirty_block  in  BLK_W  data of the probed line
- clear_en  out  1  one-cycle strobe that clears a dirty bit
- clear_way  out  2  way whose dirty bit is cleared
- clear_idx  out  3  set whose dirty bit is cleared
- proc2mem_command  out  2  0 NONE, 1 LOAD (never driven), 2 STORE
- proc2mem_addr  out  32  {tag, idx, 3'b000}
- proc2mem_data  out  BLK_W  store data
- mem2proc_response  in  RESP_W  nonzero = store accepted this cycle

Behaviour:
- Reset (reset=0, async): state IDLE, line pointer ptr={way,set}=0, latched tag/idx/data=0.
  - All outputs 0; proc2mem_command=NONE.
  - Reset mid-flush abandons the walk immediately: no flush_done, no clear_en.
- ptr is log2(NUM_WAYS)+log2(NUM_SETS) bits (5). Set is the low field, so the walk visits way0 set0..7, then way1, and so on. last = ptr all-ones.
- way_selected and rd_set_idx always drive ptr. dirty_search=1 only in PROBE.
- IDLE:
  - flush_req=1 -> PROBE with ptr=0. Otherwise stay.
  - flush_req is ignored in every other state. There is no queueing; a request during busy is lost.
- PROBE (1 cycle per line):
  - read_dirty=1: latch dirty_tag, dirty_idx, dirty_block; -> ISSUE.
  - read_dirty=0 and not last: ptr+1; stay in PROBE.
  - read_dirty=0 and last: -> DONE.
- ISSUE:
  - Drive STORE, addr={latched tag, latched idx, 3'b000}, data=latched block. These hold stable until accepted.
  - mem2proc_response==0: stay in ISSUE and retry every cycle, unbounded.
  - mem2proc_response!=0: -> CLEAR. Command returns to NONE next cycle.
- CLEAR:
  - clear_en=1 for exactly 1 cycle, with clear_way/clear_idx = ptr fields.
  - not last -> PROBE with ptr+1; last -> DONE.
- DONE: flush_done=1 for 1 cycle; -> IDLE. ptr resets to 0.
- Timing:
  - Clean cache: flush_done is asserted 33 cycles after flush_req is sampled (32 PROBE + DONE).
  - Each dirty line adds ISSUE (1 + stall cycles) + 1 CLEAR.
- Pointer wrap: ptr never wraps during a walk; last is terminal.
- Invariants:
  - At most one STORE is in flight at any time.
  - proc2mem_command is never LOAD.
  - clear_en is only asserted for a line that was stored.

Optional Feature:
- Macro: DCACHE_FLUSH_STATS_EN
- Defined:
  - Adds output wb_count (6 bits): number of lines written back in the current or last flush.
  - Adds output stall_cycles (16 bits, saturating): ISSUE cycles spent with response==0.
  - Both clear on reset and on flush start; both hold after DONE.
- Undefined: neither port exists and there is no counter logic. Core behaviour is identical.

Test Plan:
- Clean cache, flush_req pulse -> zero STOREs, no clear_en, flush_done exactly 33 cycles later, busy high throughout.
- Only way2 set5 dirty (tag 0x1234567, data 0xDEADBEEF_CAFEF00D), response=1 immediately -> one STORE with addr=0x48D159E8 and that data, then clear_en with way=2 idx=5, then done.
- Same line, response=0 for 4 cycles then 3 -> STORE held stable 5 cycles, clear_en once; with the macro defined, stall_cycles=4 and wb_count=1.
- All 32 lines dirty -> 32 STOREs in ptr order, each followed by clear_en; done after 32*3+1 cycles at single-cycle accept.
- reset=0 while in ISSUE -> command NONE and flush_busy=0 asynchronously; no clear_en or flush_done; a new flush_req restarts at ptr=0.
- flush_req held high for 3 cycles mid-walk -> ignored; exactly one flush_done for the walk, then IDLE re-samples flush_req.

Source files
------------

// File: rtl/dcache_flush_engine.sv
// Dcache flush engine: walks every {way,set} line, stores each dirty block to memory, clears its dirty bit.
// Optional DCACHE_FLUSH_STATS_EN adds wb_count / stall_cycles statistics outputs.
module dcache_flush_engine #(
  parameter int NUM_WAYS = 4,
  parameter int NUM_SETS = 8,
  parameter int TAG_W    = 26,
  parameter int BLK_W    = 64,
  parameter int RESP_W   = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        flush_req,
  output logic                        flush_busy,
  output logic                        flush_done,
  output logic                        dirty_search,
  output logic [2:0]                  way_selected,
  output logic [$clog2(NUM_SETS)-1:0] rd_set_idx,
  input  logic                        read_dirty,
  input  logic [TAG_W-1:0]            dirty_tag,
  input  logic [$clog2(NUM_SETS)-1:0] dirty_idx,
  input  logic [BLK_W-1:0]            dirty_block,
  output logic                        clear_en,
  output logic [$clog2(NUM_WAYS)-1:0] clear_way,
  output logic [$clog2(NUM_SETS)-1:0] clear_idx,
  output logic [1:0]                  proc2mem_command,
  output logic [31:0]                 proc2mem_addr,
  output logic [BLK_W-1:0]            proc2mem_data,
  input  logic [RESP_W-1:0]           mem2proc_response
`ifdef DCACHE_FLUSH_STATS_EN
  ,
  output logic [5:0]                  wb_count,
  output logic [15:0]                 stall_cycles
`endif
);

  localparam int WAY_W = $clog2(NUM_WAYS);
  localparam int SET_W = $clog2(NUM_SETS);
  localparam int PTR_W = WAY_W + SET_W;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PROBE = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_CLEAR = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [1:0] CMD_NONE  = 2'd0;
  localparam logic [1:0] CMD_STORE = 2'd2;

  logic [2:0]       state_reg, state_next;
  logic [PTR_W-1:0] ptr_reg, ptr_next;
  logic [TAG_W-1:0] tag_reg;
  logic [SET_W-1:0] idx_reg;
  logic [BLK_W-1:0] blk_reg;
  logic             latch_en;
  logic             last_line;
  logic             accepted;

  assign last_line = &ptr_reg;
  assign accepted  = (state_reg == S_ISSUE) && (mem2proc_response != '0);

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    latch_en   = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (flush_req) begin
          state_next = S_PROBE;
          ptr_next   = '0;
        end
      end
      S_PROBE: begin
        if (read_dirty) begin
          state_next = S_ISSUE;
          latch_en   = 1'b1;
        end else if (last_line) begin
          state_next = S_DONE;
        end else begin
          ptr_next = ptr_reg + 1'b1;
        end
      end
      S_ISSUE: begin
        if (accepted) state_next = S_CLEAR;
      end
      S_CLEAR: begin
        if (last_line) begin
          state_next = S_DONE;
        end else begin
          state_next = S_PROBE;
          ptr_next   = ptr_reg + 1'b1;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
        ptr_next   = '0;
      end
      default: begin
        state_next = S_IDLE;
        ptr_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= S_IDLE;
      ptr_reg   <= '0;
      tag_reg   <= '0;
      idx_reg   <= '0;
      blk_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      // Latched copy keeps the store stable while memory stalls
      if (latch_en) begin
        tag_reg <= dirty_tag;
        idx_reg <= dirty_idx;
        blk_reg <= dirty_block;
      end
    end
  end

  assign flush_busy       = (state_reg != S_IDLE);
  assign flush_done       = (state_reg == S_DONE);
  assign dirty_search     = (state_reg == S_PROBE);
  assign way_selected     = 3'(ptr_reg[PTR_W-1:SET_W]);
  assign rd_set_idx       = ptr_reg[SET_W-1:0];
  assign clear_en         = (state_reg == S_CLEAR);
  assign clear_way        = ptr_reg[PTR_W-1:SET_W];
  assign clear_idx        = ptr_reg[SET_W-1:0];
  assign proc2mem_command = (state_reg == S_ISSUE) ? CMD_STORE : CMD_NONE;
  assign proc2mem_addr    = {tag_reg, idx_reg, 3'b000};
  assign proc2mem_data    = blk_reg;

`ifdef DCACHE_FLUSH_STATS_EN
  logic flush_start;
  assign flush_start = (state_reg == S_IDLE) && flush_req;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wb_count     <= '0;
      stall_cycles <= '0;
    end else if (flush_start) begin
      wb_count     <= '0;
      stall_cycles <= '0;
    end else if (state_reg == S_ISSUE) begin
      if (accepted) wb_count <= wb_count + 1'b1;
      else if (stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_flush_engine.sv
// Bench for dcache_flush_engine: cache-array and memory models, expected store list derived from dirty bits.
// Checks wb_count / stall_cycles when DCACHE_FLUSH_STATS_EN is defined.
module tb_dcache_flush_engine;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush_req;
  logic        flush_busy, flush_done, dirty_search;
  logic [2:0]  way_selected, rd_set_idx;
  logic        read_dirty;
  logic [25:0] dirty_tag;
  logic [2:0]  dirty_idx;
  logic [63:0] dirty_block;
  logic        clear_en;
  logic [1:0]  clear_way;
  logic [2:0]  clear_idx;
  logic [1:0]  proc2mem_command;
  logic [31:0] proc2mem_addr;
  logic [63:0] proc2mem_data;
  logic [3:0]  mem2proc_response;
`ifdef DCACHE_FLUSH_STATS_EN
  logic [5:0]  wb_count;
  logic [15:0] stall_cycles;
`endif

  int vectors = 0;
  int errors  = 0;

  // Cache array model: dirty bit, tag, block per line index {way,set}
  logic        dirty_m [32];
  logic [25:0] tag_m   [32];
  logic [63:0] blk_m   [32];
  logic [4:0]  probe_line;

  always #5 clock = ~clock;

  dcache_flush_engine dut (
    .clock(clock), .reset(reset), .flush_req(flush_req),
    .flush_busy(flush_busy), .flush_done(flush_done), .dirty_search(dirty_search),
    .way_selected(way_selected), .rd_set_idx(rd_set_idx),
    .read_dirty(read_dirty), .dirty_tag(dirty_tag), .dirty_idx(dirty_idx),
    .dirty_block(dirty_block), .clear_en(clear_en), .clear_way(clear_way),
    .clear_idx(clear_idx), .proc2mem_command(proc2mem_command),
    .proc2mem_addr(proc2mem_addr), .proc2mem_data(proc2mem_data),
    .mem2proc_response(mem2proc_response)
`ifdef DCACHE_FLUSH_STATS_EN
    , .wb_count(wb_count), .stall_cycles(stall_cycles)
`endif
  );

  always_comb begin
    probe_line  = {way_selected[1:0], rd_set_idx};
    read_dirty  = dirty_m[probe_line];
    dirty_tag   = tag_m[probe_line];
    dirty_idx   = rd_set_idx;
    dirty_block = blk_m[probe_line];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // stall_mode < 0 picks a random stall per store; hold_at > 0 raises flush_req for 3 cycles mid-walk;
  // abort pulls reset low during the first store's stall.
  task automatic run_flush(input int stall_mode, input int hold_at, input bit abort);
    int lines[$];
    logic [31:0] addrs[$];
    logic [63:0] datas[$];
    int stalls[$];
    int exp_cycles, c, k, sc, clears, tot_stall, s;
    bit done_seen;
    exp_cycles = 33; tot_stall = 0;
    for (int p = 0; p < 32; p++) begin
      if (dirty_m[p]) begin
        s = (stall_mode < 0) ? int'($urandom_range(0, 3)) : stall_mode;
        lines.push_back(p);
        addrs.push_back({tag_m[p], p[2:0], 3'b000});
        datas.push_back(blk_m[p]);
        stalls.push_back(s);
        exp_cycles += 2 + s;
        tot_stall += s;
      end
    end
    @(negedge clock);
    flush_req = 1'b1;
    c = 0; k = 0; sc = 0; clears = 0; done_seen = 0;
    while (!done_seen && c < 3000) begin
      @(negedge clock);
      c++;
      flush_req = (hold_at > 0) && (c >= hold_at) && (c < hold_at + 3);
      mem2proc_response = 4'd0;
      chk("busy", flush_busy, 1'b1);
      if (proc2mem_command == 2'd2) begin
        chk("store_expected", k < lines.size(), 1'b1);
        chk("search_in_issue", dirty_search, 1'b0);
        if (k < lines.size()) begin
          chk("store_addr", proc2mem_addr, addrs[k]);
          chk("store_data", proc2mem_data, datas[k]);
          if (abort && sc == 2) begin
            reset = 1'b0;
            #1;
            chk("abort_cmd", proc2mem_command, 2'd0);
            chk("abort_busy", flush_busy, 1'b0);
            for (int i = 0; i < 3; i++) begin
              @(negedge clock);
              chk("abort_clear", clear_en, 1'b0);
              chk("abort_done", flush_done, 1'b0);
            end
            reset = 1'b1;
            flush_req = 1'b0;
            return;
          end
          if (sc == stalls[k]) begin
            mem2proc_response = 4'($urandom_range(1, 15));
            k++; sc = 0;
          end else begin
            sc++;
          end
        end
      end else begin
        chk("cmd_none", proc2mem_command, 2'd0);
      end
      if (clear_en) begin
        chk("clear_after_store", clears + 1, k);
        if (k > 0) begin
          chk("clear_line", {clear_way, clear_idx}, lines[k-1]);
          dirty_m[lines[k-1]] = 1'b0;
        end
        clears++;
      end
      if (flush_done) begin
        chk("done_cycle", c, exp_cycles);
        done_seen = 1;
      end
    end
    flush_req = 1'b0;
    mem2proc_response = 4'd0;
    chk("done_seen", done_seen, 1'b1);
    chk("store_count", k, lines.size());
    chk("clear_count", clears, lines.size());
`ifdef DCACHE_FLUSH_STATS_EN
    chk("wb_count", wb_count, lines.size());
    chk("stall_cycles", stall_cycles, tot_stall);
`endif
    @(negedge clock);
    chk("idle_busy", flush_busy, 1'b0);
    chk("idle_done", flush_done, 1'b0);
    $display("flush: lines=%0d cycles=%0d", lines.size(), c);
  endtask

  task automatic clear_cache();
    for (int p = 0; p < 32; p++) begin
      dirty_m[p] = 1'b0;
      tag_m[p]   = 26'($urandom);
      blk_m[p]   = {$urandom, $urandom};
    end
  endtask

  initial begin
    reset = 1'b0;
    flush_req = 1'b0;
    mem2proc_response = 4'd0;
    clear_cache();
    repeat (2) @(negedge clock);
    chk("rst_busy", flush_busy, 1'b0);
    chk("rst_done", flush_done, 1'b0);
    chk("rst_search", dirty_search, 1'b0);
    chk("rst_cmd", proc2mem_command, 2'd0);
    chk("rst_addr", proc2mem_addr, 32'd0);
    chk("rst_data", proc2mem_data, 64'd0);
    chk("rst_clear", clear_en, 1'b0);
    chk("rst_way", way_selected, 3'd0);
    chk("rst_set", rd_set_idx, 3'd0);
    reset = 1'b1;

    // Clean cache
    run_flush(0, 0, 0);

    // Only way2 set5 dirty, immediate accept
    dirty_m[21] = 1'b1;
    tag_m[21]   = 26'h1234567;
    blk_m[21]   = 64'hDEADBEEF_CAFEF00D;
    chk("known_addr", {tag_m[21], 3'd5, 3'b000}, 32'h48D159E8);
    run_flush(0, 0, 0);

    // Same line, 4 stall cycles
    dirty_m[21] = 1'b1;
    run_flush(4, 0, 0);

    // Every line dirty, single-cycle accept
    for (int p = 0; p < 32; p++) dirty_m[p] = 1'b1;
    run_flush(0, 0, 0);

    // Random dirty patterns with random stalls
    for (int r = 0; r < 4; r++) begin
      clear_cache();
      for (int p = 0; p < 32; p++) dirty_m[p] = 1'($urandom_range(0, 1));
      run_flush(-1, 0, 0);
    end

    // Reset during ISSUE, then restart from ptr 0
    clear_cache();
    dirty_m[3]  = 1'b1;
    dirty_m[30] = 1'b1;
    run_flush(10, 0, 1);
    run_flush(1, 0, 0);

    // flush_req held mid-walk is ignored; IDLE re-samples afterwards
    clear_cache();
    dirty_m[7]  = 1'b1;
    dirty_m[19] = 1'b1;
    run_flush(-1, 10, 0);
    run_flush(0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
